// File: rtl/osnt_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the 10G TX queue from NUM_PORTS AXI4-Stream sources.
// Define OSNT_TX_ARB_STATS_EN to build the per-port forwarded-packet counters.
module osnt_tx_arbiter #(
  parameter int AXI_DATA_WIDTH       = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 512,
  parameter int NUM_PORTS            = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*AXI_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
  output logic [NUM_PORTS-1:0]                   s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]        m_axis_tuser,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  input  logic                                   m_axis_tready,
  input  logic [NUM_PORTS-1:0]                   port_en,
  output logic                                   grant_valid,
  output logic [2:0]                             grant_idx,
  input  logic                                   stats_clear,
  output logic [NUM_PORTS*32-1:0]                pkt_cnt
);

  localparam int KEEP_W = AXI_DATA_WIDTH / 8;

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q, state_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [2:0]           grant_idx_q, grant_idx_d;
  logic [2:0]           last_grant_q, last_grant_d;

  logic [NUM_PORTS-1:0] req;
  logic [2:0]           pick;
  logic                 pkt_done;

  assign req = s_axis_tvalid & port_en;

  // Round-robin: lowest requester above last_grant, else wrap to lowest requester overall.
  always_comb begin
    logic        found_hi, found_lo;
    logic [2:0]  pick_hi, pick_lo;
    int unsigned last_u;
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    last_u   = 32'(last_grant_q);
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (req[p] && (p > last_u) && !found_hi) begin
        pick_hi  = 3'(p);
        found_hi = 1'b1;
      end
      if (req[p] && !found_lo) begin
        pick_lo  = 3'(p);
        found_lo = 1'b1;
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == SEND) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (grant_idx_q == 3'(p)) begin
          m_axis_tdata     = s_axis_tdata[p*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
          m_axis_tkeep     = s_axis_tkeep[p*KEEP_W +: KEEP_W];
          m_axis_tuser     = s_axis_tuser[p*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
          m_axis_tvalid    = s_axis_tvalid[p];
          m_axis_tlast     = s_axis_tlast[p];
          s_axis_tready[p] = m_axis_tready;
        end
      end
    end
  end

  assign pkt_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    last_grant_d  = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d       = SEND;
          grant_valid_d = 1'b1;
          grant_idx_d   = pick;
          last_grant_d  = pick;
        end
      end
      SEND: begin
        if (pkt_done) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      last_grant_q  <= 3'(NUM_PORTS - 1);
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

`ifdef OSNT_TX_ARB_STATS_EN
  logic [NUM_PORTS-1:0][31:0] cnt_q, cnt_d;

  // Clear takes priority over a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (stats_clear) begin
      cnt_d = '0;
    end else if (pkt_done) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (grant_idx_q == 3'(p)) cnt_d[p] = cnt_q[p] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pkt_cnt = cnt_q;
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_osnt_tx_arbiter.sv
// Directed scoreboard bench for osnt_tx_arbiter; expected beats are queued as packets are loaded.
module tb_osnt_tx_arbiter;

  localparam int DW = 32;
  localparam int UW = 32;
  localparam int NP = 4;
  localparam int KW = DW / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP*UW-1:0]  s_tuser;
  logic [NP-1:0]     s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic              m_tvalid, m_tlast, m_tready;
  logic [NP-1:0]     port_en;
  logic              grant_valid;
  logic [2:0]        grant_idx;
  logic              stats_clear;
  logic [NP*32-1:0]  pkt_cnt;

  osnt_tx_arbiter #(
    .AXI_DATA_WIDTH(DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .NUM_PORTS(NP)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .port_en(port_en), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .stats_clear(stats_clear), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          gap;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } sbeat_t;

  typedef struct {
    int     port;
    int     cyc;
    sbeat_t b;
  } ebeat_t;

  sbeat_t src_q[NP][$];
  ebeat_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = -100;
  int en_cyc, clr_cyc;
  logic [NP-1:0] en_val;
  bit tready_toggle;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic sbeat_t mk_beat(int port, int id, int b, int nb);
    sbeat_t r;
    r.gap  = 1'b0;
    r.data = {8'(port), 8'(id), 16'(b)};
    r.keep = (b == nb - 1) ? 4'b0011 : 4'b1111;
    r.user = {16'(id), 16'(nb * 4 - 2)};
    r.last = (b == nb - 1);
    return r;
  endfunction

  task automatic push_exp(int port, int id, int b, int nb, int c);
    ebeat_t e;
    e.port = port;
    e.cyc  = c;
    e.b    = mk_beat(port, id, b, nb);
    exp_q.push_back(e);
  endtask

  // Beat b lands at start+b, shifted by gap_len once past the gap.
  task automatic load_pkt(int port, int id, int nb, int gap_after, int gap_len, int start, bit expect_out);
    sbeat_t g;
    g = '{default: 0};
    g.gap = 1'b1;
    for (int b = 0; b < nb; b++) begin
      src_q[port].push_back(mk_beat(port, id, b, nb));
      if (b == gap_after) for (int k = 0; k < gap_len; k++) src_q[port].push_back(g);
      if (expect_out)
        push_exp(port, id, b, nb,
                 (start < 0) ? -1 : start + b + ((gap_after >= 0 && b > gap_after) ? gap_len : 0));
    end
  endtask

  task automatic drive();
    if (cyc == en_cyc) port_en = en_val;
    stats_clear = (cyc == clr_cyc);
    if (tready_toggle) m_tready = ~m_tready;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() == 0 || src_q[p][0].gap) begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
        s_tdata[p*DW +: DW] = '0;
        s_tkeep[p*KW +: KW] = '0;
        s_tuser[p*UW +: UW] = '0;
      end else begin
        s_tvalid[p] = 1'b1;
        s_tlast[p]  = src_q[p][0].last;
        s_tdata[p*DW +: DW] = src_q[p][0].data;
        s_tkeep[p*KW +: KW] = src_q[p][0].keep;
        s_tuser[p*UW +: UW] = src_q[p][0].user;
      end
    end
  endtask

  task automatic mon_step();
    ebeat_t e;
    @(negedge clk);
    if (grant_valid && exp_q.size() > 0) begin
      chk("grant_idx", grant_idx, exp_q[0].port);
      chk("s_tready_send", s_tready, NP'(m_tready) << exp_q[0].port);
    end else if (!grant_valid) begin
      chk("s_tready_idle", s_tready, 0);
      chk("m_tvalid_idle", m_tvalid, 0);
    end
    if (m_tvalid && m_tready) begin
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("beat", {m_tdata, m_tkeep, m_tuser, m_tlast}, {e.b.data, e.b.keep, e.b.user, e.b.last});
        if (e.cyc >= 0) chk("beat_cycle", cyc, e.cyc);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        if (src_q[p][0].gap || (s_tvalid[p] && s_tready[p])) void'(src_q[p].pop_front());
      end
    end
  endtask

  task automatic drv_step();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run(int max_cyc);
    int guard = 0;
    while (exp_q.size() > 0 && guard < max_cyc) begin
      mon_step();
      drv_step();
      guard++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic flush();
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    flush();
    port_en = '1;
    m_tready = 1'b1;
    tready_toggle = 1'b0;
    en_cyc = -1;
    clr_cyc = -1;
    cyc = -100;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic start_test();
    cyc = 0;
    drive();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_dut();
    @(negedge clk);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);

    // All ports, 3 beats each: rotation 0..3 with one idle cycle between packets
    reset_dut();
    for (int p = 0; p < NP; p++) load_pkt(p, p + 1, 3, -1, 0, 1 + 4 * p, 1'b1);
    start_test();
    run(200);
`ifdef OSNT_TX_ARB_STATS_EN
    chk("cnt_rotation", pkt_cnt, {32'd1, 32'd1, 32'd1, 32'd1});
`else
    chk("cnt_tied", pkt_cnt, 0);
`endif

    // Port 2: single beat, then 5 beats with a 2-cycle bubble after beat 1
    reset_dut();
    load_pkt(2, 11, 1, -1, 0, 1, 1'b1);
    load_pkt(2, 12, 5, 1, 2, 3, 1'b1);
    start_test();
    run(200);

    // Port 1 4-beat packet under toggling ready, port 2 waiting behind it
    reset_dut();
    tready_toggle = 1'b1;
    load_pkt(1, 21, 4, -1, 0, -1, 1'b1);
    load_pkt(2, 22, 1, -1, 0, -1, 1'b1);
    start_test();
    run(200);

    // Enable mask 1011, port 0 disabled mid-packet: 0 then 1,3,1,3
    reset_dut();
    port_en = 4'b1011;
    en_cyc = 2;
    en_val = 4'b1010;
    load_pkt(0, 31, 3, -1, 0, 1, 1'b1);
    load_pkt(1, 32, 3, -1, 0, 5, 1'b1);
    load_pkt(3, 33, 3, -1, 0, 9, 1'b1);
    load_pkt(1, 34, 3, -1, 0, 13, 1'b1);
    load_pkt(3, 35, 3, -1, 0, 17, 1'b1);
    load_pkt(2, 36, 3, -1, 0, -1, 1'b0);
    load_pkt(2, 37, 3, -1, 0, -1, 1'b0);
    start_test();
    run(200);

    // Reset during beat 2 of a 4-beat port 3 packet
    reset_dut();
    load_pkt(3, 41, 4, -1, 0, -1, 1'b0);
    push_exp(3, 41, 0, 4, 1);
    push_exp(3, 41, 1, 4, 2);
    start_test();
    repeat (3) begin
      mon_step();
      drv_step();
    end
    reset = 1'b1;
    m_tready = 1'b0;
    mon_step();
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    m_tready = 1'b1;
    flush();
    load_pkt(0, 42, 1, -1, 0, 5, 1'b1);
    load_pkt(3, 43, 1, -1, 0, 7, 1'b1);
    drive();
    mon_step();
    chk("post_rst_grant_valid", grant_valid, 0);
    chk("post_rst_grant_idx", grant_idx, 0);
    drv_step();
    run(200);

    // Counter wrap and clear-versus-increment
    reset_dut();
`ifdef OSNT_TX_ARB_STATS_EN
    force dut.cnt_q[0] = 32'hFFFF_FFFF;
    mon_step();
    drv_step();
    release dut.cnt_q[0];
    chk("cnt_preload", pkt_cnt[31:0], 32'hFFFF_FFFF);
`endif
    load_pkt(0, 51, 1, -1, 0, 1, 1'b1);
    start_test();
    run(100);
    chk("cnt_wrap", pkt_cnt[31:0], 0);
    load_pkt(1, 52, 1, -1, 0, 1, 1'b1);
    load_pkt(1, 53, 1, -1, 0, 3, 1'b1);
    start_test();
    clr_cyc = 3;
    run(100);
    chk("cnt_clear_wins", pkt_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
